// File: rtl/tx_iq_intf_mc_if.sv
// TX I/Q streaming bus between tx core, the interface block and the DAC side.
// Slave modport is the interface block; master is the tx core / DAC driver.
interface tx_iq_intf_mc_if #(
    parameter int IQ_DATA_WIDTH = 16,
    parameter int NUM_CH        = 1
);
    logic [NUM_CH*2*IQ_DATA_WIDTH-1:0] rf_iq;
    logic                              rf_iq_valid;
    logic                              tx_hold;
    logic [NUM_CH*2*IQ_DATA_WIDTH-1:0] wifi_iq_pack;
    logic                              wifi_iq_valid;
    logic                              wifi_iq_ready;

    modport master (
        output rf_iq, rf_iq_valid, wifi_iq_ready,
        input  tx_hold, wifi_iq_pack, wifi_iq_valid
    );
    modport slave (
        input  rf_iq, rf_iq_valid, wifi_iq_ready,
        output tx_hold, wifi_iq_pack, wifi_iq_valid
    );
endinterface

// File: rtl/tx_iq_intf_mc.sv
// Multi-channel TX I/Q interface: per-channel gain with rounding, FWFT FIFO, tx_hold hysteresis.
// Define TX_IQ_INTF_SAT_EN to saturate scaled samples instead of wrapping them.
module tx_iq_lane #(
    parameter int W = 16,
    parameter int G = 10,
    parameter int F = 7
) (
    input  logic           clk,
    input  logic [2*W-1:0] iq,
    input  logic [G-1:0]   gain,
    output logic [2*W-1:0] iq_out
);
    localparam int PW = W + G;
    localparam logic signed [PW:0] RND = (PW+1)'(1) << (F - 1);
`ifdef TX_IQ_INTF_SAT_EN
    localparam logic signed [PW:0] MAXV = {{(G+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [PW:0] MINV = {{(G+2){1'b1}}, {(W-1){1'b0}}};
`endif

    logic signed [PW-1:0] prod_i, prod_q;

    function automatic logic [W-1:0] scale(input logic signed [PW-1:0] p);
        logic signed [PW:0] r;
        r = ((PW+1)'(p) + RND) >>> F;
`ifdef TX_IQ_INTF_SAT_EN
        if (r > MAXV)      return {1'b0, {(W-1){1'b1}}};
        else if (r < MINV) return {1'b1, {(W-1){1'b0}}};
        else               return W'(r);
`else
        return W'(r);
`endif
    endfunction

    always_ff @(posedge clk) begin
        prod_i <= PW'($signed(iq[W-1:0]))   * PW'($signed(gain));
        prod_q <= PW'($signed(iq[2*W-1:W])) * PW'($signed(gain));
        iq_out <= {scale(prod_q), scale(prod_i)};
    end
endmodule

module tx_iq_intf_mc #(
    parameter int IQ_DATA_WIDTH   = 16,
    parameter int NUM_CH          = 1,
    parameter int GAIN_WIDTH      = 10,
    parameter int GAIN_FRAC_BITS  = 7,
    parameter int FIFO_DEPTH_LOG2 = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    tx_iq_intf_mc_if.slave               bus,
    input  logic [NUM_CH*GAIN_WIDTH-1:0] bb_gain,
    input  logic [FIFO_DEPTH_LOG2:0]     tx_hold_thresh_hi,
    input  logic [FIFO_DEPTH_LOG2:0]     tx_hold_thresh_lo,
    input  logic                         underrun_clr,
    output logic                         tx_iq_fifo_empty,
    output logic [FIFO_DEPTH_LOG2:0]     fifo_data_count,
    output logic [15:0]                  underrun_cnt,
    output logic                         overflow_sticky
);
    localparam int W     = IQ_DATA_WIDTH;
    localparam int WW    = NUM_CH * 2 * W;
    localparam int AW    = FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

    typedef enum logic {RUN, HOLD} hold_e;
    hold_e state, state_nxt;

    logic [2:1]    vld_pipe;
    logic          v_in, rd_en, wr_ok, full, empty, valid_q;
    logic [WW-1:0] s2_word;
    logic [WW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        tx_iq_lane #(.W(W), .G(GAIN_WIDTH), .F(GAIN_FRAC_BITS)) u_lane (
            .clk    (clk),
            .iq     (bus.rf_iq[c*2*W +: 2*W]),
            .gain   (bb_gain[c*GAIN_WIDTH +: GAIN_WIDTH]),
            .iq_out (s2_word[c*2*W +: 2*W])
        );
    end

    assign v_in  = bus.rf_iq_valid & ~bus.tx_hold;
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rd_en = bus.wifi_iq_ready & ~empty;
    // A full FIFO still accepts the write when the head leaves in the same cycle.
    assign wr_ok = vld_pipe[2] & (~full | rd_en);

    assign bus.wifi_iq_pack  = empty ? '0 : mem[rd_ptr];
    assign bus.wifi_iq_valid = valid_q & ~rst;
    assign tx_iq_fifo_empty  = empty;
    assign fifo_data_count   = count;

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= s2_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe        <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            overflow_sticky <= 1'b0;
            underrun_cnt    <= '0;
            valid_q         <= 1'b0;
            state           <= RUN;
        end else begin
            vld_pipe <= {vld_pipe[1], v_in};
            valid_q  <= 1'b1;
            state    <= state_nxt;
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (vld_pipe[2] && full && !rd_en) overflow_sticky <= 1'b1;
            if (underrun_clr)
                underrun_cnt <= '0;
            else if (bus.wifi_iq_ready && empty && underrun_cnt != 16'hFFFF)
                underrun_cnt <= underrun_cnt + 16'd1;
        end
    end

    // tx_hold follows the next state so the core is stalled in the very cycle the threshold is hit.
    always_comb begin
        state_nxt = state;
        if (tx_hold_thresh_lo >= tx_hold_thresh_hi) begin
            state_nxt = (count >= tx_hold_thresh_hi) ? HOLD : RUN;
        end else begin
            case (state)
                RUN:     if (count >= tx_hold_thresh_hi) state_nxt = HOLD;
                HOLD:    if (count <= tx_hold_thresh_lo) state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end
        bus.tx_hold = ~rst & (state_nxt == HOLD);
    end
endmodule

// File: tb/tb_tx_iq_intf_mc.sv
// Directed bench for tx_iq_intf_mc with two channels; expected values computed by hand.
module tb_tx_iq_intf_mc;
    logic        clk, rst, underrun_clr, empty, ovf;
    logic [19:0] bb_gain;
    logic [9:0]  hi, lo, count;
    logic [15:0] ucnt;
    logic [63:0] exp_sat;
    int          n_chk, n_err;

    tx_iq_intf_mc_if #(.IQ_DATA_WIDTH(16), .NUM_CH(2)) bus ();

    tx_iq_intf_mc #(.NUM_CH(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus),
        .bb_gain           (bb_gain),
        .tx_hold_thresh_hi (hi),
        .tx_hold_thresh_lo (lo),
        .underrun_clr      (underrun_clr),
        .tx_iq_fifo_empty  (empty),
        .fifo_data_count   (count),
        .underrun_cnt      (ucnt),
        .overflow_sticky   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ch0 i=n q=-n, ch1 i=n+256 q=-(n+256); unity gain returns the same word
    function automatic logic [63:0] mkw(input int n);
        return {16'(-(n + 256)), 16'(n + 256), 16'(-n), 16'(n)};
    endfunction

    initial begin
        n_chk = 0; n_err = 0;
        rst = 1'b1; underrun_clr = 1'b0; hi = 10'd400; lo = 10'd100;
        bb_gain = {10'h080, 10'h080};
        bus.rf_iq = '0; bus.rf_iq_valid = 1'b0; bus.wifi_iq_ready = 1'b0;
        step(); step();
        chk("rst_valid", bus.wifi_iq_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_hold", bus.tx_hold, 0);
        rst = 1'b0;
        step();
        chk("post_valid", bus.wifi_iq_valid, 1);
        chk("rst_ovf", ovf, 0);
        chk("rst_ucnt", ucnt, 0);
        chk("rst_pack", bus.wifi_iq_pack, 0);

        // ramp passthrough and latency
        for (int k = 1; k <= 4; k++) begin
            bus.rf_iq = mkw(k); bus.rf_iq_valid = 1'b1;
            step();
            if (k == 1) chk("lat_c1", count, 0);
            if (k == 2) chk("lat_c2_empty", empty, 1);
            if (k == 3) begin
                chk("lat_c3_count", count, 1);
                chk("lat_c3_head", bus.wifi_iq_pack, mkw(1));
            end
        end
        bus.rf_iq_valid = 1'b0;
        step(); step();
        chk("ramp_count", count, 4);
        bus.wifi_iq_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("ramp_data", bus.wifi_iq_pack, mkw(k));
            step();
        end
        bus.wifi_iq_ready = 1'b0;
        chk("ramp_empty", empty, 1);

        // gain, rounding and clipping/wrap
        bb_gain = {10'h040, 10'h100};
        bus.rf_iq = {16'hFFFD, 16'h0003, 16'hBFFF, 16'h4000};
        bus.rf_iq_valid = 1'b1;
        step();
        bus.rf_iq_valid = 1'b0;
        step(); step();
`ifdef TX_IQ_INTF_SAT_EN
        exp_sat = {16'hFFFF, 16'h0002, 16'h8000, 16'h7FFF};
`else
        exp_sat = {16'hFFFF, 16'h0002, 16'h7FFE, 16'h8000};
`endif
        chk("sat_count", count, 1);
        chk("sat_word", bus.wifi_iq_pack, exp_sat);
        bus.wifi_iq_ready = 1'b1;
        step();
        bus.wifi_iq_ready = 1'b0;
        bb_gain = {10'h080, 10'h080};
        chk("sat_empty", empty, 1);

        // underrun counting and clear priority
        bus.wifi_iq_ready = 1'b1;
        repeat (5) step();
        chk("ucnt_5", ucnt, 5);
        chk("ucnt_pack", bus.wifi_iq_pack, 0);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0; bus.wifi_iq_ready = 1'b0;
        chk("ucnt_clr", ucnt, 0);

        // hysteresis
        bus.rf_iq = mkw(7); bus.rf_iq_valid = 1'b1;
        for (int t = 0; t < 1000 && !bus.tx_hold; t++) step();
        chk("hold_rise", bus.tx_hold, 1);
        chk("hold_rise_count", count, 400);
        repeat (5) step();
        chk("hold_stop_count", count, 402);
        chk("hold_no_ovf", ovf, 0);
        bus.wifi_iq_ready = 1'b1;
        for (int t = 0; t < 1000 && bus.tx_hold; t++) step();
        chk("hold_fall", bus.tx_hold, 0);
        chk("hold_fall_count", count, 100);
        bus.rf_iq_valid = 1'b0;
        for (int t = 0; t < 1000 && !empty; t++) step();
        bus.wifi_iq_ready = 1'b0;
        chk("hold_drained", empty, 1);

        // overflow with threshold above depth
        hi = 10'd600;
        for (int k = 0; k < 520; k++) begin
            bus.rf_iq = mkw(k); bus.rf_iq_valid = 1'b1;
            step();
        end
        bus.rf_iq_valid = 1'b0;
        step(); step(); step();
        chk("ovf_count", count, 512);
        chk("ovf_sticky", ovf, 1);
        chk("ovf_hold", bus.tx_hold, 0);
        bus.wifi_iq_ready = 1'b1;
        for (int k = 0; k < 512; k++) begin
            chk("ovf_drain", bus.wifi_iq_pack, mkw(k));
            step();
        end
        bus.wifi_iq_ready = 1'b0;
        chk("ovf_empty", empty, 1);
        chk("ovf_ucnt", ucnt, 0);

        // reset mid-stream
        hi = 10'd400;
        for (int k = 1; k <= 5; k++) begin
            bus.rf_iq = mkw(k + 20); bus.rf_iq_valid = 1'b1;
            step();
        end
        bus.rf_iq_valid = 1'b0; rst = 1'b1;
        step();
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_hold", bus.tx_hold, 0);
        chk("mid_rst_valid", bus.wifi_iq_valid, 0);
        chk("mid_rst_ovf", ovf, 0);
        rst = 1'b0;
        step(); step(); step();
        chk("mid_rst_flushed", empty, 1);
        bus.rf_iq = mkw(99); bus.rf_iq_valid = 1'b1;
        step();
        bus.rf_iq_valid = 1'b0;
        step(); step();
        chk("post_rst_count", count, 1);
        chk("post_rst_head", bus.wifi_iq_pack, mkw(99));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
